// File: rtl/fetch_req_gen.sv
// Fetch request generator: walks a predicted PC stream, issues block-aligned
// instruction memory requests and returns in-order fetch packets through a small queue.
module fetch_req_gen #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h6000_0000,
    localparam int         SW          = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int         BLK         = 4 * FETCH_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic [31:0]               pred_pc,
    input  logic                      pred_taken,
    input  logic [SW-1:0]             pred_slot,
    input  logic [31:0]               pred_target,
    output logic                      imem_req,
    input  logic                      imem_ready,
    output logic [31:0]               imem_addr,
    output logic [BLK-1:0]            imem_rmask,
    input  logic                      imem_resp,
    input  logic [32*FETCH_WIDTH-1:0] imem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [32*FETCH_WIDTH-1:0] out_instr,
    output logic [FETCH_WIDTH-1:0]    out_mask,
    output logic                      out_pred_taken
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [31:0]            pc;
        logic [FETCH_WIDTH-1:0] mask;
        logic                   pred_taken;
    } meta_t;

    logic [31:0]               fetch_pc;
    logic [PW-1:0]             head_ptr;
    logic [PW-1:0]             tail_ptr;
    logic [PW-1:0]             resp_ptr;
    logic [CW-1:0]             count;
    logic [QUEUE_DEPTH-1:0]    q_stale;
    logic [QUEUE_DEPTH-1:0]    q_has_data;
    meta_t                     q_meta [QUEUE_DEPTH];
    logic [32*FETCH_WIDTH-1:0] q_data [QUEUE_DEPTH];

    logic [SW-1:0]          offset;
    logic                   pred_eff;
    logic [FETCH_WIDTH-1:0] alloc_mask;
    logic [31:0]            block_pc;
    logic [31:0]            next_pc;
    logic                   accept;
    logic                   head_done;
    logic                   pop;
    logic [PW-1:0]          resp_dist;
    logic                   resp_ok;

    // Slot decode: the block is trimmed below the entry offset and after a taken slot.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        alloc_mask = '0;
        offset     = SW'((fetch_pc >> 2) & 32'(FETCH_WIDTH - 1));
        pred_eff   = pred_taken && (pred_slot >= offset);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            alloc_mask[i] = (SW'(i) >= offset) && (!pred_eff || (SW'(i) <= pred_slot));
        end
        block_pc = fetch_pc & ~32'(BLK - 1);
        next_pc  = pred_eff ? pred_target : block_pc + 32'(BLK);
    end

    assign pred_pc    = fetch_pc;
    assign imem_addr  = block_pc;
    assign imem_rmask = {BLK{1'b1}};
    assign imem_req   = !rst && !redirect_valid && (count < CW'(QUEUE_DEPTH));
    assign accept     = imem_req && imem_ready;

    assign head_done      = (count != '0) && q_has_data[head_ptr];
    assign out_valid      = head_done && !q_stale[head_ptr];
    assign pop            = (out_valid && out_ready) || (head_done && q_stale[head_ptr]);
    assign out_pc         = q_meta[head_ptr].pc;
    assign out_mask       = q_meta[head_ptr].mask;
    assign out_pred_taken = q_meta[head_ptr].pred_taken;
    assign out_instr      = q_data[head_ptr];

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            resp_ptr   <= '0;
            count      <= '0;
            q_stale    <= '0;
            q_has_data <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (accept) begin
                fetch_pc <= next_pc;
            end

            if (accept) begin
                tail_ptr             <= tail_ptr + PW'(1);
                q_has_data[tail_ptr] <= 1'b0;
                q_stale[tail_ptr]    <= 1'b0;
            end

            // A response landing in a redirect cycle still fills; the stale mark below wins.
            if (imem_resp) begin
                q_has_data[resp_ptr] <= 1'b1;
                resp_ptr             <= resp_ptr + PW'(1);
            end

            if (redirect_valid) begin
                q_stale <= '1;
            end

            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end

            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (!accept && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // NOTE: payload storage carries no reset; validity is tracked by count and the flag bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_meta[tail_ptr] <= '{pc: fetch_pc, mask: alloc_mask, pred_taken: pred_eff};
        end
        if (imem_resp) begin
            q_data[resp_ptr] <= imem_rdata;
        end
    end

    // A response must target an allocated entry that is still waiting for data.
    assign resp_dist = resp_ptr - head_ptr;
    assign resp_ok   = (count != '0) && (CW'(resp_dist) < count) && !q_has_data[resp_ptr];

    resp_has_pending_entry: assert property (
        @(posedge clk) disable iff (rst) imem_resp |-> resp_ok
    );

endmodule

// File: tb/tb_fetch_req_gen.sv
// Directed bench for fetch_req_gen (FETCH_WIDTH=2, QUEUE_DEPTH=4) with a
// one-cycle in-order memory responder and logs of accepted requests and delivered packets.
module tb_fetch_req_gen;
    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
        logic        pt;
        logic [63:0] instr;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [0:0]  pred_slot = '0;
    logic [31:0] pred_target = '0;
    logic        imem_req;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_addr;
    logic [7:0]  imem_rmask;
    logic        imem_resp = 1'b0;
    logic [63:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [63:0] out_instr;
    logic [1:0]  out_mask;
    logic        out_pred_taken;

    logic        pred_en = 1'b0;
    logic [31:0] pred_at = '0;
    logic        mem_auto = 1'b1;
    logic [31:0] mem_q[$];
    logic [31:0] acc_log[$];
    pkt_t        out_log[$];
    int          n_checks = 0;
    int          n_fail = 0;

    assign pred_taken = pred_en && (pred_pc == pred_at);

    fetch_req_gen dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_slot      (pred_slot),
        .pred_target    (pred_target),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_mask       (out_mask),
        .out_pred_taken (out_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] blk(input logic [31:0] a);
        return {(a + 32'd4) ^ K, a ^ K};
    endfunction

    function automatic pkt_t get_pkt(input int k);
        pkt_t p;
        p = '{pc: 32'hDEAD_DEAD, mask: 2'b00, pt: 1'b0, instr: 64'd0};
        if (k < out_log.size()) p = out_log[k];
        return p;
    endfunction

    function automatic logic [31:0] get_acc(input int k);
        if (k < acc_log.size()) return acc_log[k];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe accepts and deliveries mid-cycle, when all inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ready) begin
                acc_log.push_back(imem_addr);
                mem_q.push_back(imem_addr);
            end
            if (out_valid && out_ready) begin
                out_log.push_back('{pc: out_pc, mask: out_mask, pt: out_pred_taken, instr: out_instr});
            end
        end
    end

    // In-order memory returning each accepted block one cycle later.
    always @(posedge clk) begin
        #1;
        if (mem_auto) begin
            if (!rst && mem_q.size() > 0) begin
                imem_resp  = 1'b1;
                imem_rdata = blk(mem_q.pop_front());
            end else begin
                imem_resp = 1'b0;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        mem_q.delete();
        acc_log.delete();
        out_log.delete();
        run(2);
    endtask

    initial begin
        int leaks;

        // Reset state
        sample();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pred_pc", pred_pc, 32'h6000_0000);

        // Straight-line fetch after reset release
        run(1);
        rst = 1'b0;
        sample();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h6000_0000);
        check("rmask_ones", imem_rmask, 8'hFF);
        run(10);
        check("seq_acc0", get_acc(0), 32'h6000_0000);
        check("seq_acc1", get_acc(1), 32'h6000_0008);
        check("seq_acc2", get_acc(2), 32'h6000_0010);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("seq_pc%0d", k), get_pkt(k).pc, 32'h6000_0000 + 32'(8 * k));
            check($sformatf("seq_mask%0d", k), get_pkt(k).mask, 2'b11);
        end
        check("seq_instr0", get_pkt(0).instr, 64'hC5A5_0004_C5A5_0000);

        // Redirect into the middle of a block
        do_reset();
        imem_ready = 1'b0;
        rst = 1'b0;
        run(1);
        check("hold_addr", imem_addr, 32'h6000_0000);
        redirect_valid = 1'b1;
        redirect_pc = 32'h6000_0104;
        sample();
        check("redir_req_low", imem_req, 1'b0);
        run(1);
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        sample();
        check("redir_addr", imem_addr, 32'h6000_0100);
        check("redir_pred_pc", pred_pc, 32'h6000_0104);
        run(8);
        check("redir_acc0", get_acc(0), 32'h6000_0100);
        check("redir_acc1", get_acc(1), 32'h6000_0108);
        check("redir_out_pc", get_pkt(0).pc, 32'h6000_0104);
        check("redir_out_mask", get_pkt(0).mask, 2'b10);

        // Taken prediction at slot 0 of an aligned block
        do_reset();
        pred_en = 1'b1;
        pred_at = 32'h6000_0000;
        pred_slot = 1'b0;
        pred_target = 32'h6000_0200;
        rst = 1'b0;
        run(8);
        check("pred_acc0", get_acc(0), 32'h6000_0000);
        check("pred_acc1", get_acc(1), 32'h6000_0200);
        check("pred_mask0", get_pkt(0).mask, 2'b01);
        check("pred_pt0", get_pkt(0).pt, 1'b1);
        check("pred_pc1", get_pkt(1).pc, 32'h6000_0200);
        check("pred_mask1", get_pkt(1).mask, 2'b11);
        check("pred_pt1", get_pkt(1).pt, 1'b0);

        // Prediction on a slot before the entry offset is ignored
        do_reset();
        pred_at = 32'h6000_0004;
        imem_ready = 1'b0;
        rst = 1'b0;
        run(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h6000_0004;
        run(1);
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        run(8);
        check("nopred_acc0", get_acc(0), 32'h6000_0000);
        check("nopred_acc1", get_acc(1), 32'h6000_0008);
        check("nopred_pc0", get_pkt(0).pc, 32'h6000_0004);
        check("nopred_mask0", get_pkt(0).mask, 2'b10);
        check("nopred_pt0", get_pkt(0).pt, 1'b0);
        pred_en = 1'b0;

        // Back-pressure: queue fills, one pop re-enables requests a cycle later
        do_reset();
        out_ready = 1'b0;
        rst = 1'b0;
        run(8);
        sample();
        check("full_accepts", acc_log.size(), 4);
        check("full_req_low", imem_req, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        check("full_out_pc", out_pc, 32'h6000_0000);
        run(2);
        check("stall_out_pc", out_pc, 32'h6000_0000);
        out_ready = 1'b1;
        sample();
        check("pop_cycle_req", imem_req, 1'b0);
        run(1);
        out_ready = 1'b0;
        sample();
        check("after_pop_req", imem_req, 1'b1);
        check("after_pop_pc", out_pc, 32'h6000_0008);
        run(1);
        out_ready = 1'b1;
        run(12);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("order_pc%0d", k), get_pkt(k).pc, 32'h6000_0000 + 32'(8 * k));
        end

        // Redirect with one filled (in the redirect cycle) and two pending entries
        do_reset();
        mem_auto = 1'b0;
        out_ready = 1'b1;
        imem_ready = 1'b1;
        rst = 1'b0;
        for (int g = 0; g < 10 && acc_log.size() < 3; g++) sample();
        check("flush_three_acc", acc_log.size(), 3);
        run(1);
        imem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h6000_0300;
        imem_resp = 1'b1;
        imem_rdata = (mem_q.size() > 0) ? blk(mem_q.pop_front()) : 64'd0;
        sample();
        check("flush_req_low", imem_req, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        run(1);
        redirect_valid = 1'b0;
        imem_resp = 1'b0;
        imem_ready = 1'b1;
        mem_auto = 1'b1;
        run(12);
        leaks = 0;
        foreach (out_log[k]) if (out_log[k].pc < 32'h6000_0300) leaks++;
        check("flush_no_stale_out", leaks, 0);
        check("flush_first_pc", get_pkt(0).pc, 32'h6000_0300);
        check("flush_first_mask", get_pkt(0).mask, 2'b11);
        check("flush_first_instr", get_pkt(0).instr, 64'hC5A5_0304_C5A5_0300);

        // Reset while the queue is full
        do_reset();
        out_ready = 1'b0;
        rst = 1'b0;
        run(8);
        sample();
        check("prefull_req", imem_req, 1'b0);
        run(1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_imem_req", imem_req, 1'b0);
        do_reset();
        rst = 1'b0;
        out_ready = 1'b1;
        sample();
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, 32'h6000_0000);
        run(6);
        check("restart_out_pc", get_pkt(0).pc, 32'h6000_0000);
        check("restart_acc1", get_acc(1), 32'h6000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fetch_req_gen.md
FETCH_REQ_GEN -- requirements
Module: fetch_req_gen

Interface
REQ-001 Parameter FETCH_WIDTH, default 2: instructions per fetch block; legal values 1, 2, 4.
REQ-002 Parameter QUEUE_DEPTH, default 4: maximum in-flight plus buffered fetch blocks; power of 2, 2..16.
REQ-003 Parameter RESET_PC, default 32'h60000000: PC after reset.
REQ-004 Derived: SW = max(1, clog2(FETCH_WIDTH)); BLK = 4*FETCH_WIDTH bytes.
REQ-005 Timing and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 redirect_valid  in  1  backend mispredict/flush.
REQ-009 redirect_pc  in  32  corrected PC; word aligned.
REQ-010 pred_pc  out  32  current fetch PC, driven to the external predictor/BTB.
REQ-011 pred_taken  in  1  predictor says taken within block at pred_pc (combinational).
REQ-012 pred_slot  in  SW  slot index of the predicted-taken instruction.
REQ-013 pred_target  in  32  predicted target.
REQ-014 imem_req  out  1  request valid.
REQ-015 imem_ready  in  1  memory accepts request this cycle.
REQ-016 imem_addr  out  32  block-aligned request address.
REQ-017 imem_rmask  out  BLK  byte read mask; all ones whenever imem_req=1.
REQ-018 imem_resp  in  1  response valid; in order, at least 1 cycle after acceptance.
REQ-019 imem_rdata  in  32*FETCH_WIDTH  response block; slot i in bits [32i+31:32i].
REQ-020 out_valid  out  1  fetch packet valid to decode.
REQ-021 out_ready  in  1  decode accepts packet.
REQ-022 out_pc / out_instr / out_mask / out_pred_taken  out  32 / 32*FETCH_WIDTH / FETCH_WIDTH / 1  packet PC, instructions, valid slots, prediction flag.

Function
REQ-023 State: fetch PC register; circular queue of QUEUE_DEPTH entries {pc, mask, pred_taken, stale, has_data, data}; head, tail, resp pointers; occupancy count 0..QUEUE_DEPTH.
REQ-024 pred_pc = fetch PC; imem_addr = fetch PC with low clog2(BLK) bits cleared.
REQ-025 imem_req = 1 iff count < QUEUE_DEPTH and redirect_valid = 0.
REQ-026 Accept = imem_req and imem_ready; on accept, allocate entry at tail with has_data=0, stale=0; fetch PC updates to next PC.
REQ-027 Offset slot o = fetch PC[clog2(BLK)-1:2] (0 when FETCH_WIDTH=1); prediction effective iff pred_taken and pred_slot >= o.
REQ-028 Entry mask bit i = 1 iff i >= o and (prediction not effective or i <= pred_slot).
REQ-029 Next PC: prediction effective -> pred_target; else block-aligned fetch PC + BLK (32-bit wrap).
REQ-030 No accept and no redirect: fetch PC holds; imem_addr stable while imem_req held.
REQ-031 Redirect: fetch PC <= redirect_pc next cycle; every queue entry marked stale; imem_req = 0 that cycle; any unaccepted request is void.
REQ-032 imem_resp writes imem_rdata into entry at resp pointer, sets has_data, advances resp pointer; response in a redirect cycle still fills, entry is stale.
REQ-033 out_valid = head entry present, has_data, not stale; out_* driven from head entry.
REQ-034 Pop: out_valid and out_ready; or head present, has_data and stale (silent discard, no out_valid). At most one pop per cycle.
REQ-035 Simultaneous accept and pop: count unchanged; both pointers advance mod QUEUE_DEPTH.
REQ-036 Full (count = QUEUE_DEPTH): no request; pop in same cycle does not enable request until next cycle.
REQ-037 Empty: out_valid = 0; responses with no pending entry are a protocol error (assertion).
REQ-038 out_* stable while out_valid=1 and out_ready=0, unless redirect.

Reset
REQ-039 While rst=1: fetch PC = RESET_PC, count = 0, all pointers 0, imem_req = 0, out_valid = 0, all entries invalid.
REQ-040 First request issued in first cycle after rst deasserts, imem_addr = RESET_PC aligned.
REQ-041 rst mid-operation discards all entries; responses for pre-reset requests are not permitted by the memory side.

Verification (FETCH_WIDTH=2, QUEUE_DEPTH=4)
REQ-042 Reset release, imem_ready=1, 1-cycle responses, out_ready=1 -> imem_addr 0x60000000, 0x60000008, 0x60000010; out_mask 2'b11 each.
REQ-043 redirect_pc 0x60000104 -> next imem_addr 0x60000100, out_pc 0x60000104, out_mask 2'b10; following addr 0x60000108.
REQ-044 pred_taken=1, pred_slot=0, pred_target 0x60000200 at pc 0x60000000 -> out_mask 2'b01, out_pred_taken=1, next imem_addr 0x60000200; pred_slot=0 at pc 0x60000004 -> prediction ignored, next 0x60000008.
REQ-045 out_ready=0, imem_ready=1 -> exactly 4 accepts, then imem_req=0; one pop re-enables request next cycle; packets emerge in order.
REQ-046 Redirect with 3 entries outstanding (1 filled, 2 pending) -> none of them reach out_valid; first packet out is redirect target; count returns to 0 before target entry only.
REQ-047 Assert rst while queue full -> out_valid and imem_req 0 immediately, fetch restarts at 0x60000000.
